// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with a start/busy/op_done handshake and short-circuit paths for zero divisors and illegal ops.
module seq_muldiv #(
    parameter int OP_SZ = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [OP_SZ-1:0] mult0,
    input  logic [OP_SZ-1:0] mult1,
    output logic [OP_SZ-1:0] out,
    output logic             busy,
    output logic             op_done,
    output logic             err,
    output logic             div_zero
);

    localparam int CW = $clog2(OP_SZ + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [2*OP_SZ-1:0]   acc;
    logic [OP_SZ-1:0]     divisor;
    logic [2:0]           op_r;
    logic                 neg_q;
    logic                 neg_r;
    logic [CW-1:0]        cnt;

    logic                 a_signed, b_signed;
    logic                 a_neg, b_neg;
    logic [OP_SZ-1:0]     a_mag, b_mag;
    logic [OP_SZ:0]       mul_sum;
    logic [OP_SZ:0]       div_cand;
    logic [OP_SZ:0]       div_diff;
    logic                 div_qbit;
    logic [OP_SZ-1:0]     div_rem;
    logic [2*OP_SZ-1:0]   prod;

    function automatic logic [OP_SZ-1:0] magnitude(input logic signed [OP_SZ-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[OP_SZ-1]) ? OP_SZ'(-v) : OP_SZ'(v);
    endfunction

    function automatic logic [OP_SZ-1:0] cond_neg(input logic [OP_SZ-1:0] v, input logic neg);
        return neg ? OP_SZ'(-v) : v;
    endfunction

    function automatic logic [2*OP_SZ-1:0] cond_neg_wide(input logic [2*OP_SZ-1:0] v,
                                                         input logic neg);
        return neg ? (2*OP_SZ)'(-v) : v;
    endfunction

    always_comb begin
        a_signed = (op == 4'd1) || (op == 4'd2) || (op == 4'd4) || (op == 4'd6);
        b_signed = (op == 4'd1) || (op == 4'd4) || (op == 4'd6);
        a_neg    = a_signed && mult0[OP_SZ-1];
        b_neg    = b_signed && mult1[OP_SZ-1];
        a_mag    = magnitude(mult0, a_signed);
        b_mag    = magnitude(mult1, b_signed);
    end

    // Multiply step: add multiplicand into the high half when the multiplier LSB is set.
    assign mul_sum  = {1'b0, acc[2*OP_SZ-1:OP_SZ]} + (acc[0] ? {1'b0, divisor} : '0);
    // Divide step: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign div_cand = acc[2*OP_SZ-1:OP_SZ-1];
    assign div_diff = div_cand - {1'b0, divisor};
    assign div_qbit = ~div_diff[OP_SZ];
    assign div_rem  = div_qbit ? div_diff[OP_SZ-1:0] : div_cand[OP_SZ-1:0];
    assign prod     = cond_neg_wide(acc, neg_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out      <= '0;
            busy     <= 1'b0;
            op_done  <= 1'b0;
            err      <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            divisor  <= '0;
            op_r     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The op_done cycle is still IDLE but must not accept a new job.
                    if (start && !op_done) begin
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        div_zero <= 1'b0;
                        op_r     <= op[2:0];
                        cnt      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (op[3]) begin
                            out   <= '0;
                            err   <= 1'b1;
                            state <= DONE;
                        end else if (op[2] && (mult1 == '0)) begin
                            out      <= op[1] ? mult0 : '1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            divisor <= op[2] ? b_mag : a_mag;
                            acc     <= {{OP_SZ{1'b0}}, (op[2] ? a_mag : b_mag)};
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_r[2])
                        acc <= {div_rem, acc[OP_SZ-2:0], div_qbit};
                    else
                        acc <= {mul_sum, acc[OP_SZ-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(OP_SZ - 1))
                        state <= FIX;
                end
                FIX: begin
                    case (op_r)
                        3'd0:          out <= prod[OP_SZ-1:0];
                        3'd1, 3'd2, 3'd3: out <= prod[2*OP_SZ-1:OP_SZ];
                        3'd4, 3'd5:    out <= cond_neg(acc[OP_SZ-1:0], neg_q);
                        default:       out <= cond_neg(acc[2*OP_SZ-1:OP_SZ], neg_r);
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    op_done <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
Parametrised iterative multiply/divide unit. It generalises the existing square/multiply block: operand width is configurable, signed and unsigned multiply-high, divide and remainder modes are added, and an explicit start/busy/done handshake replaces reset-as-start. It sits beside the ALU in the MCU datapath and is shared by MUL/DIV instructions.

Parameters:
OP_SZ, 32, operand and result width in bits (even, >= 4).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  4  operation code, latched with start
mult0  input  OP_SZ  multiplicand / dividend, latched with start
mult1  input  OP_SZ  multiplier / divisor, latched with start
out  output  OP_SZ  result; held from op_done until the next accepted start
busy  output  1  high from the cycle after an accepted start until op_done
op_done  output  1  one-cycle pulse; out valid in that cycle
err  output  1  illegal op flag; valid with op_done, held with out
div_zero  output  1  divisor was zero (ops 4-7); valid with op_done, held with out

Behaviour:
- Reset: out=0, busy=0, op_done=0, err=0, div_zero=0, state=IDLE, internal registers cleared. Reset mid-operation aborts it; no op_done is produced.
- op encoding: 0 MUL (low OP_SZ bits), 1 MULH (signed x signed, high), 2 MULHSU (signed mult0 x unsigned mult1, high), 3 MULHU (unsigned, high), 4 DIV (signed), 5 DIVU, 6 REM (signed), 7 REMU. Codes 8-15 are illegal.
- Operands and op are latched on the accepted-start edge; input changes afterwards have no effect.
- FSM: IDLE -> CALC on start; CALC -> FIX after exactly OP_SZ iterations; FIX -> DONE; DONE -> IDLE (op_done=1 only in DONE). Illegal op or divide-by-zero: IDLE -> DONE directly.
- Normal latency: op_done is high in the cycle after edge N+OP_SZ+2, where N is the accepted-start edge. Short-circuit latency: op_done is high after edge N+1.
- start is ignored while busy or in DONE; start in the op_done cycle is not accepted.
- MUL family: operands are converted to magnitudes per signedness. CALC runs 1-bit shift-add into a 2*OP_SZ accumulator. FIX negates the product if the sign bits differ (signed ops only), then selects low or high half.
- DIV family: operands are converted to magnitudes. CALC runs restoring division, one quotient bit per cycle. FIX sets the quotient sign to sign(a) XOR sign(b) and the remainder sign to sign(a).
- Divide by zero: DIV/DIVU out = all ones; REM/REMU out = mult0; div_zero=1.
- Signed overflow (mult0 = most negative value, mult1 = -1): DIV out = mult0; REM out = 0. Computed through the normal path, no flag.
- Illegal op: out=0, err=1.
- err and div_zero clear on the next accepted start.

Test Plan:
- Reset, op=0, mult0=5, mult1=4, start pulse -> busy rises next cycle; op_done pulses once at edge N+34 (OP_SZ=32); out=20; busy low in op_done cycle.
- Back-to-back jobs: op=0 with 420x600 -> out=252000. Then op=5 with 600/7 -> out=85. Then op=7 with 600%7 -> out=5. Each is started the cycle after the previous op_done.
- Signed ops: op=1 with -3x7 -> out=0xFFFFFFFF. op=3 with 0xFFFFFFFF x 0xFFFFFFFF -> out=0xFFFFFFFE. op=4 with -7/2 -> out=0xFFFFFFFD. op=6 with -7%2 -> out=0xFFFFFFFF.
- Corner cases: op=4 with 9/0 -> out=0xFFFFFFFF, div_zero=1, op_done after 2 edges. op=6 with 9%0 -> out=9. op=4 with 0x80000000/0xFFFFFFFF -> out=0x80000000. op=9 -> err=1, out=0.
- Handshake: assert start again mid-CALC with different operands -> ignored; result matches the original operands.
- Change mult0 during CALC -> no effect on the result.
- Assert reset at iteration 10 -> all outputs 0, no op_done. A fresh start afterwards completes normally.
